// File: rtl/aclock.sv
// -----------------------------------------------------------------------------
// aclock : 24-hour digital clock with a single alarm.
//
// Keeps HH:MM:SS in binary counters, advanced by a one-second tick derived from
// clk by a CLK_PER_SEC divider. Time and alarm can be loaded from BCD digit
// inputs; loads with an out-of-range hour/minute or a units digit above 9 are
// ignored. Alarm is set when a registered update (tick rolling into a new
// minute, or a time load) makes the time equal the alarm HH:MM with seconds 00,
// provided AL_ON is high. STOP_al or AL_ON low clear it, with priority over set.
//
// Optional build macro: ACLOCK_ALARM_TIMEOUT_EN
//   defined   : an unstopped Alarm clears itself 60 ticks after its set event
//   undefined : Alarm stays high until STOP_al or AL_ON=0
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   H_in1/H_in0         hour tens (0-2) / units (BCD) to load
//   M_in1/M_in0         minute tens (0-5) / units (BCD) to load
//   LD_time             load the digits into the current time (seconds clear)
//   LD_alarm            load the digits into the alarm setting
//   STOP_al             clear an active Alarm
//   AL_ON               alarm enable
//   Alarm               alarm ringing (registered)
//   H_out*/M_out*/S_out* current time as BCD digits (registered)
// -----------------------------------------------------------------------------
module aclock #(
  parameter int CLK_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_time,
  input  logic       LD_alarm,
  input  logic       STOP_al,
  input  logic       AL_ON,
  output logic       Alarm,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0
);

  localparam int              DIV_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SEC - 1);

  // Binary timekeeping state
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       hr_q, hr_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [4:0]       al_hr_q, al_hr_d;
  logic [5:0]       al_min_q, al_min_d;
  logic             alarm_q, alarm_d;

  // Registered BCD view of the time, so every output comes from a flop
  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] m0_q, m0_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s0_q, s0_d;

`ifdef ACLOCK_ALARM_TIMEOUT_EN
  logic [5:0] to_cnt_q, to_cnt_d;
`endif

  // Decode of the load digits (wide enough that bad digits cannot alias)
  logic [5:0] ld_hr;
  logic [7:0] ld_min;
  logic       ld_ok;
  logic       time_ld;
  logic       alarm_ld;
  logic       tick;
  logic       set_event;

  assign ld_hr    = 6'(H_in1) * 6'd10 + 6'(H_in0);
  assign ld_min   = 8'(M_in1) * 8'd10 + 8'(M_in0);
  assign ld_ok    = (H_in0 <= 4'd9) && (M_in0 <= 4'd9) &&
                    (ld_hr <= 6'd23) && (ld_min <= 8'd59);
  assign time_ld  = LD_time && ld_ok;
  assign alarm_ld = LD_alarm && ld_ok;
  assign tick     = (div_q == DIV_LAST);

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

  // Time / divider next state. A valid time load wins over a tick.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    if (time_ld) begin
      hr_d  = ld_hr[4:0];
      min_d = ld_min[5:0];
      sec_d = 6'd0;
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Alarm setting register
  always_comb begin
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    if (alarm_ld) begin
      al_hr_d  = ld_hr[4:0];
      al_min_d = ld_min[5:0];
    end
  end

  // The set event looks at the time being written this edge and compares it
  // against the alarm setting held before this edge.
  assign set_event = (time_ld || tick) && (sec_d == 6'd0) &&
                     (hr_d == al_hr_q) && (min_d == al_min_q);

  always_comb begin
    alarm_d = alarm_q;
`ifdef ACLOCK_ALARM_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    if (!AL_ON || STOP_al) begin
      alarm_d = 1'b0;
    end else if (set_event) begin
      alarm_d = 1'b1;
`ifdef ACLOCK_ALARM_TIMEOUT_EN
      to_cnt_d = 6'd0;
`endif
    end
`ifdef ACLOCK_ALARM_TIMEOUT_EN
    // Only ticks that actually advance the time count towards the timeout.
    else if (alarm_q && tick && !time_ld) begin
      if (to_cnt_q == 6'd59) begin
        alarm_d = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + 6'd1;
      end
    end
`endif
  end

  // BCD digits of the next time value
  always_comb begin
    if (hr_d >= 5'd20) begin
      h1_d = 2'd2;
      h0_d = 4'(hr_d - 5'd20);
    end else if (hr_d >= 5'd10) begin
      h1_d = 2'd1;
      h0_d = 4'(hr_d - 5'd10);
    end else begin
      h1_d = 2'd0;
      h0_d = 4'(hr_d);
    end
    {m1_d, m0_d} = to_bcd(min_d);
    {s1_d, s0_d} = to_bcd(sec_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      hr_q     <= 5'd0;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      al_hr_q  <= 5'd0;
      al_min_q <= 6'd0;
      alarm_q  <= 1'b0;
      h1_q     <= 2'd0;
      h0_q     <= 4'd0;
      m1_q     <= 4'd0;
      m0_q     <= 4'd0;
      s1_q     <= 4'd0;
      s0_q     <= 4'd0;
`ifdef ACLOCK_ALARM_TIMEOUT_EN
      to_cnt_q <= 6'd0;
`endif
    end else begin
      div_q    <= div_d;
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      alarm_q  <= alarm_d;
      h1_q     <= h1_d;
      h0_q     <= h0_d;
      m1_q     <= m1_d;
      m0_q     <= m0_d;
      s1_q     <= s1_d;
      s0_q     <= s0_d;
`ifdef ACLOCK_ALARM_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign Alarm  = alarm_q;
  assign H_out1 = h1_q;
  assign H_out0 = h0_q;
  assign M_out1 = m1_q;
  assign M_out0 = m0_q;
  assign S_out1 = s1_q;
  assign S_out0 = s0_q;

endmodule

// File: tb/tb_aclock.sv
// -----------------------------------------------------------------------------
// tb_aclock : scoreboard bench for aclock.
// Each stimulus cycle updates a seconds-of-day reference model and queues the
// expected outputs; a monitor pops one entry after every rising edge and
// compares it with the DUT. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_aclock;

  localparam int CPS = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] H_in1 = '0;
  logic [3:0] H_in0 = '0;
  logic [3:0] M_in1 = '0;
  logic [3:0] M_in0 = '0;
  logic       LD_time = 1'b0;
  logic       LD_alarm = 1'b0;
  logic       STOP_al = 1'b0;
  logic       AL_ON = 1'b0;
  logic       Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  always #5 clk = ~clk;

  aclock #(.CLK_PER_SEC(CPS)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .Alarm(Alarm), .H_out1(H_out1), .H_out0(H_out0),
    .M_out1(M_out1), .M_out0(M_out0), .S_out1(S_out1), .S_out0(S_out0)
  );

  typedef logic [22:0] obs_t;   // {alarm, h1, h0, m1, m0, s1, s0}

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_act;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: time as seconds since midnight, alarm as minute of day
  int m_t, m_div, m_al_min, m_age;
  bit m_alarm;
  bit cur_on;

  function automatic obs_t model_obs();
    int h, m, s;
    h = m_t / 3600;
    m = (m_t / 60) % 60;
    s = m_t % 60;
    return {m_alarm, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("AL=%0d %0d%0d:%0d%0d:%0d%0d", o[22], o[21:20], o[19:16],
                     o[15:12], o[11:8], o[7:4], o[3:0]);
  endfunction

  function automatic obs_t dut_obs();
    return {Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  endfunction

  // Monitor: one comparison per registered cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = dut_obs();
        n_tests++;
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got %s, expected %s", $time,
                   fmt(mon_act), fmt(mon_exp));
        end
      end
    end
  end

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic step(input bit lt, input bit la, input int h1, input int h0,
                      input int m1, input int m0, input bit st);
    int  hv, mv;
    bit  valid, upd, tk, ev;
    H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
    LD_time = lt; LD_alarm = la; STOP_al = st; AL_ON = cur_on;

    hv    = 10 * int'(H_in1) + int'(H_in0);
    mv    = 10 * int'(M_in1) + int'(M_in0);
    valid = (H_in0 <= 9) && (M_in0 <= 9) && (hv <= 23) && (mv <= 59);
    upd = 0; tk = 0;
    if (lt && valid) begin
      m_t = hv * 3600 + mv * 60; m_div = 0; upd = 1;
    end else if (m_div == CPS - 1) begin
      m_div = 0; m_t = (m_t + 1) % 86400; upd = 1; tk = 1;
    end else begin
      m_div++;
    end
    ev = upd && (m_t % 60 == 0) && (m_t / 60 == m_al_min);
    if (st || !cur_on) m_alarm = 0;
    else if (ev) begin
      m_alarm = 1; m_age = 0;
    end
`ifdef ACLOCK_ALARM_TIMEOUT_EN
    else if (m_alarm && tk) begin
      m_age++;
      if (m_age >= 60) m_alarm = 0;
    end
`endif
    if (la && valid) m_al_min = hv * 60 + mv;
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_time(input int h, input int m);
    step(1, 0, h / 10, h % 10, m / 10, m % 10, 0);
  endtask

  task automatic load_alarm(input int h, input int m);
    step(0, 1, h / 10, h % 10, m / 10, m % 10, 0);
  endtask

  task automatic model_reset();
    m_t = 0; m_div = 0; m_al_min = 0; m_alarm = 0; m_age = 0;
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge.
  task automatic reset_check();
    obs_t act;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    act = dut_obs();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %s, expected %s", fmt(act), fmt('0));
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic int pick_hour();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 12;
    if (r < 7) return 23;
    return $urandom_range(0, 29);
  endfunction

  function automatic int pick_min();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 34;
    if (r < 6) return 35;
    if (r < 8) return 59;
    return $urandom_range(0, 65);
  endfunction

  initial begin
    int h, m, wait_cnt;
    model_reset();
    cur_on = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset from 12:34:56 mid-second
    idle(3);
    load_time(12, 34);
    idle(56 * CPS + 5);
    reset_check();

    // Basic counting
    load_time(12, 34);
    idle(CPS);
    idle(59 * CPS);

    // Day wrap and ignored loads
    load_time(23, 59);
    idle(60 * CPS + 3);
    step(1, 0, 2, 4, 0, 0, 0);    // 24:00
    step(1, 0, 1, 0, 6, 0, 0);    // 10:60
    step(1, 0, 1, 10, 0, 0, 0);   // units digit 10
    step(1, 0, 3, 0, 0, 0, 0);    // 30:00
    step(0, 1, 2, 5, 0, 0, 0);    // bad alarm load
    idle(15);

    // Alarm rises on rollover, STOP clears it
    cur_on = 1;
    load_alarm(12, 35);
    load_time(12, 34);
    idle(60 * CPS);
    idle(5);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(60 * CPS);

    // Alarm disabled through the event, enabled later in the minute
    cur_on = 0;
    load_time(12, 34);
    idle(60 * CPS + 30 * CPS);
    cur_on = 1;
    idle(30 * CPS);

    // STOP on the exact set-event edge
    load_time(12, 34);
    idle(60 * CPS - 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(20);

    // Unstopped alarm, new alarm load while ringing, set by LD_time, held load
    load_time(12, 34);
    idle(60 * CPS);
    load_alarm(7, 0);
    idle(70 * CPS);
    cur_on = 0;
    step(0, 0, 0, 0, 0, 0, 0);
    cur_on = 1;
    load_alarm(12, 35);
    repeat (4) load_time(12, 35);
    idle(CPS + 2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit lt, la, st;
      lt = ($urandom_range(0, 99) < 2);
      la = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) cur_on = ~cur_on;
      h = pick_hour();
      m = pick_min();
      step(lt, la, h / 10, h % 10, m / 10, m % 10, st);
    end

    // Drain the scoreboard with a bound
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aclock.md
Name: aclock

Overview:
24-hour digital clock with a single alarm. Keeps HH:MM:SS from a divided system clock, accepts time and alarm loads, and raises Alarm when the time reaches the alarm setting while the alarm is enabled. It is a standalone timekeeping leaf block; its BCD digit outputs drive display logic.

Parameters:
CLK_PER_SEC, 10, clk cycles per one-second tick (integer >= 1; default matches the 10 Hz system clock)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
H_in1  in  2  hour tens digit to load (0-2)
H_in0  in  4  hour units digit to load, BCD
M_in1  in  4  minute tens digit to load (0-5)
M_in0  in  4  minute units digit to load, BCD
LD_time  in  1  load H_in/M_in into current time when high
LD_alarm  in  1  load H_in/M_in into alarm registers when high
STOP_al  in  1  clear an active Alarm
AL_ON  in  1  alarm enable
Alarm  out  1  alarm ringing, registered
H_out1  out  2  current hour tens
H_out0  out  4  current hour units
M_out1  out  4  current minute tens
M_out0  out  4  current minute units
S_out1  out  4  current second tens
S_out0  out  4  current second units

Behaviour:
- Reset (reset=0, async): time 00:00:00, alarm 00:00, divider 0, Alarm=0. All outputs come directly from registers.
- Divider: counts 0..CLK_PER_SEC-1. A tick fires in the cycle where the divider equals CLK_PER_SEC-1, after which it wraps to 0.
- On a tick, seconds increment 00..59 with wrap to 00, carrying into minutes. Minutes increment 00..59 with wrap, carrying into hours. Hours increment 00..23 and then wrap to 00:00:00.
- Internal counters are binary. Outputs are BCD: tens = value/10, units = value%10.
- LD_time=1 at a clk edge, when the inputs are valid:
  - Hours = 10*H_in1 + H_in0 and minutes = 10*M_in1 + M_in0.
  - Seconds and the divider clear to 0.
  - Takes priority over a tick in the same cycle.
  - Holding LD_time high reloads every cycle, so time is frozen.
- LD_alarm=1 at a clk edge, when the inputs are valid: loads the alarm hour and minute. This is independent of LD_time; both may load in the same cycle.
- Validity: hour <= 23, minute <= 59, each units digit <= 9. An invalid load is ignored entirely and the registers keep their previous values.
- Alarm set event: the registered update that makes the current time equal alarm HH:MM with seconds 00. This is either a tick rolling into that minute or an LD_time load. The event sets Alarm in the same edge, if AL_ON=1 at that edge.
- Alarm clear:
  - STOP_al=1 or AL_ON=0 at a clk edge forces Alarm=0.
  - Clear has priority over set in the same cycle.
- Once set, Alarm stays high until cleared. After clearing, it re-arms only on the next set event, i.e. 24 h later or on a new LD_time.
- Loading a new alarm time does not clear an active Alarm.

Optional Feature:
ACLOCK_ALARM_TIMEOUT_EN.
- Defined: an active Alarm auto-clears after 60 ticks (60 s) if not stopped. The timeout count restarts on each set event.
- Undefined: Alarm stays high indefinitely until STOP_al or AL_ON=0.

Test Plan:
- Reset low mid-count with time 12:34:56 -> all digit outputs 0 and Alarm=0 immediately, without waiting for a clk edge.
- Hold reset high, pulse LD_time one cycle with 1,2,3,4 -> outputs 12:34:00. After 10 clk (CLK_PER_SEC=10) S_out0=1. After 600 clk, time is 12:35:00.
- Load 23:59:00, run 60 ticks -> 00:00:00. Load H_in1=2,H_in0=4 (24:xx) or M_in1=6 -> time unchanged.
- LD_alarm 12:35, AL_ON=1, time 12:34:00, run 60 ticks -> Alarm rises on the edge time becomes 12:35:00. Pulse STOP_al -> Alarm 0 next edge and stays 0 through 12:35:59.
- Same setup with AL_ON=0 at 12:35:00 -> Alarm never rises. Raise AL_ON at 12:35:30 -> Alarm stays 0.
- STOP_al=1 on the exact set-event edge -> Alarm stays 0. With ACLOCK_ALARM_TIMEOUT_EN, unstopped Alarm falls after 60 ticks.
